// File: rtl/move_sequencer.sv
// Move sequencer: buffers chunks of stepper move codes in a FIFO and issues them
// one at a time, waiting for completion, spacing moves apart and timing out a stuck stepper.
module move_sequencer #(
  parameter int MOVE_W  = 4,
  parameter int CHUNK   = 50,
  parameter int DEPTH   = 64,
  parameter int GAP     = 25000,
  parameter int TIMEOUT = 25000000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [CHUNK*MOVE_W-1:0] chunk,
  input  logic                    seq_complete,
  input  logic                    step_mode,
  input  logic                    step,
  input  logic                    pause,
  input  logic                    flush,
  input  logic                    move_done,
  output logic [MOVE_W-1:0]       next_move,
  output logic                    start_move,
  output logic                    push_ack,
  output logic                    overflow,
  output logic                    fault,
  output logic                    busy,
  output logic                    seq_done,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             moves_executed
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = $clog2(CHUNK + 1);
  localparam int PADN = (DEPTH > CHUNK) ? DEPTH : CHUNK;
  localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW   = $clog2(CMAX + 2);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP,
    ST_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level_q, level_d;
  logic [MOVE_W-1:0]  next_move_q, next_move_d;
  logic               start_move_q, start_move_d;
  logic               push_ack_q;
  logic               overflow_q;
  logic               fault_q, fault_d;
  logic               seq_done_q, seq_done_d;
  logic               armed_q, armed_d;
  logic [15:0]        moves_q, moves_d;

  logic [LW-1:0]            chunk_len;
  logic                     len_found;
  logic [LW-1:0]            wr_count;
  logic [31:0]              free_slots;
  logic                     push_ok, fits, accept, reject, pop;
  logic [PADN*MOVE_W-1:0]   chunk_pad;
  logic [DEPTH*MOVE_W-1:0]  mem_flat;
  logic [MOVE_W-1:0]        head;

  // A chunk ends at its first zero code; everything after it is padding.
  always_comb begin
    len_found = 1'b0;
    chunk_len = LW'(CHUNK);
    for (int i = 0; i < CHUNK; i++) begin
      if (!len_found && chunk[i*MOVE_W +: MOVE_W] == '0) begin
        len_found = 1'b1;
        chunk_len = LW'(i);
      end
    end
  end

  assign free_slots = 32'(DEPTH) - 32'(level_q);
  assign push_ok    = push && !flush;
  assign fits       = free_slots >= 32'(chunk_len);
  assign accept     = push_ok && fits;
  assign reject     = push_ok && !fits;
  assign wr_count   = accept ? chunk_len : '0;
  assign chunk_pad  = (PADN*MOVE_W)'(chunk);

  // Each cell takes slot (cell - wr_ptr) of the chunk, so a whole chunk lands in one cycle.
  for (genvar e = 0; e < DEPTH; e++) begin : g_cell
    logic [AW-1:0]     off;
    logic [MOVE_W-1:0] cell_q;
    assign off = AW'(e) - wr_ptr_q;
    always_ff @(posedge clock) begin
      if (accept && (32'(off) < 32'(chunk_len))) begin
        cell_q <= chunk_pad[off*MOVE_W +: MOVE_W];
      end
    end
    assign mem_flat[e*MOVE_W +: MOVE_W] = cell_q;
  end

  assign head = mem_flat[rd_ptr_q*MOVE_W +: MOVE_W];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    next_move_d  = next_move_q;
    start_move_d = 1'b0;
    fault_d      = fault_q;
    moves_d      = moves_q;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (level_q != '0 && !pause && !fault_q && !flush && (!step_mode || step)) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flush || level_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          pop = 1'b1;
          if (head == MOVE_W'(1)) begin
            state_d = ST_IDLE;
          end else begin
            next_move_d  = head;
            start_move_d = 1'b1;
            cnt_d        = '0;
            state_d      = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (move_done) begin
          next_move_d = '0;
          if (moves_q != 16'hFFFF) begin
            moves_d = moves_q + 16'd1;
          end
          cnt_d = '0;
          if (GAP == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end else if (cnt_q == TO_LAST) begin
          next_move_d = '0;
          fault_d     = 1'b1;
          state_d     = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FAULT: begin
        if (flush) begin
          fault_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_d  = flush ? '0 : level_q + (AW+1)'(wr_count) - (AW+1)'(pop);
    wr_ptr_d = wr_ptr_q + AW'(wr_count);
    rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + AW'(pop);
    // Fire once per sequence: re-armed only when real moves are accepted.
    seq_done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE) && (level_d == '0)
                 && seq_complete && armed_q;
    armed_d = armed_q;
    if (seq_done_d) begin
      armed_d = 1'b0;
    end else if (accept && chunk_len != '0) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      next_move_q  <= '0;
      start_move_q <= 1'b0;
      push_ack_q   <= 1'b0;
      overflow_q   <= 1'b0;
      fault_q      <= 1'b0;
      seq_done_q   <= 1'b0;
      armed_q      <= 1'b0;
      moves_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      next_move_q  <= next_move_d;
      start_move_q <= start_move_d;
      push_ack_q   <= accept;
      overflow_q   <= flush ? 1'b0 : (overflow_q || reject);
      fault_q      <= fault_d;
      seq_done_q   <= seq_done_d;
      armed_q      <= armed_d;
      moves_q      <= moves_d;
    end
  end

  assign next_move      = next_move_q;
  assign start_move     = start_move_q;
  assign push_ack       = push_ack_q;
  assign overflow       = overflow_q;
  assign fault          = fault_q;
  assign busy           = (state_q != ST_IDLE) || (level_q != '0);
  assign seq_done       = seq_done_q;
  assign level          = level_q;
  assign moves_executed = moves_q;

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameters SHALL be: MOVE_W default 4, width of one move code; CHUNK default 50, moves per pushed chunk; DEPTH default 64, FIFO capacity in moves (power of 2); GAP default 25000, idle cycles between moves; TIMEOUT default 25000000, maximum cycles to wait for move_done.
REQ-002 Ports SHALL be:
- clock  in  1  system clock (25 MHz).
- reset_n  in  1  reset.
- push  in  1  append chunk.
- chunk  in  CHUNK*MOVE_W  packed moves; slot 0 = bits [MOVE_W-1:0], executed first.
- seq_complete  in  1  no further chunks follow.
- step_mode  in  1  one move per step pulse.
- step  in  1  single-cycle step request.
- pause  in  1  hold before next issue.
- flush  in  1  discard queued moves.
- move_done  in  1  stepper completion pulse.
- next_move  out  MOVE_W  move code to stepper.
- start_move  out  1  one-cycle start pulse.
- push_ack  out  1  chunk accepted.
- overflow  out  1  sticky, chunk rejected.
- fault  out  1  sticky, move_done timeout.
- busy  out  1  not IDLE or FIFO non-empty.
- seq_done  out  1  one-cycle sequence-finished pulse.
- level  out  $clog2(DEPTH)+1  moves queued.
- moves_executed  out  16  completed-move count.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.

Function
REQ-004 Chunk length SHALL be the index of the first slot whose code is 0 (CHUNK if none); slots from the first 0 onward SHALL be ignored.
REQ-005 On push, if DEPTH-level (level sampled before any same-cycle pop) >= chunk length, SHALL write the valid moves in slot order and pulse push_ack next cycle; otherwise SHALL drop the whole chunk and set overflow.
REQ-006 A zero-length chunk SHALL be acknowledged with no FIFO change.
REQ-007 Code 1 SHALL be stored but skipped at issue, with no start_move and no counter increment.
REQ-008 FSM states SHALL be IDLE, ISSUE, WAIT_DONE, GAP, FAULT.
REQ-009 IDLE->ISSUE SHALL occur when the FIFO is non-empty, pause=0, fault=0, and (step_mode=0 or step=1 this cycle).
REQ-010 ISSUE SHALL pop one move, drive next_move, and assert start_move for exactly one cycle, then enter WAIT_DONE; next_move SHALL hold until move_done.
REQ-011 WAIT_DONE SHALL go to GAP on move_done, incrementing moves_executed (saturating at 16'hFFFF).
REQ-012 GAP SHALL count GAP cycles, then return to IDLE; GAP=0 SHALL mean a direct return.
REQ-013 If move_done is absent for TIMEOUT cycles in WAIT_DONE, SHALL set fault and enter FAULT; FAULT exits only via flush (to IDLE, fault cleared) or reset.
REQ-014 move_done outside WAIT_DONE SHALL be ignored.
REQ-015 A step pulse in any state other than IDLE SHALL be discarded, not queued.
REQ-016 Pause SHALL never abort an in-flight move.
REQ-017 flush SHALL empty the FIFO, clear overflow, and clear fault; an in-flight move SHALL still complete and be counted.
REQ-018 A push coincident with flush SHALL be ignored.
REQ-019 seq_done SHALL pulse once on the transition into IDLE with an empty FIFO and seq_complete=1, and not again until a new move is accepted.
REQ-020 Simultaneous push and pop SHALL update level by (written - 1).

Reset
REQ-021 Asserting reset_n low SHALL, regardless of clock, force IDLE, empty the FIFO, and zero next_move, start_move, push_ack, overflow, fault, seq_done, level and moves_executed; a mid-move reset SHALL abandon the move.

Verification
REQ-022 Push chunk {R,U,0,...}, GAP=4, move_done 10 cycles after each start_move -> start_move with 2 then 4, moves_executed=2, seq_done one pulse.
REQ-023 DEPTH=64, push a 50-move chunk and then a 20-move chunk -> second push rejected, overflow=1, level=50.
REQ-024 step_mode=1, 3 moves queued, one step pulse -> exactly one start_move; a step during WAIT_DONE produces no extra move.
REQ-025 No move_done for TIMEOUT cycles -> fault=1, no further start_move; flush -> fault=0, level=0, IDLE.
REQ-026 reset_n low during WAIT_DONE -> all outputs 0 immediately; no start_move after release until a new push.
